sig_diff_mc: RTL and testbench

Parametrised, multi-channel lagged-difference stage for the ECG front end. It accepts a valid-qualified stream of channel-interleaved signed samples. Per sample it produces either a first difference x[n]−x[n−L] or a second difference x[n]−2x[n−L]+x[n−2L], with the lag L selectable at run time. It sits between the sample acquisition path and the feature/CNN input buffers, and supersedes the fixed single-channel, lag-1 differencer.

---
 rtl/sig_diff_mc_if.sv | 27 ++
 rtl/sig_diff_mc.sv | 168 ++++++++++++++++
 tb/tb_sig_diff_mc.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/sig_diff_mc_if.sv
// Stream bundle for the multi-channel lagged differencer: sample-side inputs
// and result-side outputs. There is no back-pressure in either direction.
interface sig_diff_mc_if #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 1,
  parameter int MAX_LAG = 4,
  parameter int LAG_W   = $clog2(MAX_LAG + 1),
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] Xin;
  logic [LAG_W-1:0]         lag;
  logic                     mode;
  logic                     out_valid;
  logic signed [DATA_W+1:0] Yout;
  logic [CH_W-1:0]          out_ch;

  modport master (
    output in_valid, Xin, lag, mode,
    input  out_valid, Yout, out_ch
  );

  modport slave (
    input  in_valid, Xin, lag, mode,
    output out_valid, Yout, out_ch
  );
endinterface

// File: rtl/sig_diff_mc.sv
// Multi-channel lagged first/second difference with run-time lag, two-stage
// pipeline (history read + operand capture, then full-width arithmetic).
module sig_diff_mc #(
  parameter int DATA_W  = 8,
  parameter int NUM_CH  = 1,
  parameter int MAX_LAG = 4,
  parameter int LAG_W   = $clog2(MAX_LAG + 1)
) (
  input logic          clk,
  input logic          rst,
  input logic          clr,
  sig_diff_mc_if.slave bus
);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OUT_W  = DATA_W + 2;
  localparam int HIST_D = 2 * MAX_LAG;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [OUT_W-1:0]  wide_t;

  logic            flush;
  logic [CH_W-1:0] ch_cnt_reg;
  logic [CH_W-1:0] ch_cnt_next;
  logic [LAG_W-1:0] lag_next;
  sample_t         ch_hl  [NUM_CH];
  sample_t         ch_h2l [NUM_CH];
  sample_t         cur_hl;
  sample_t         cur_h2l;

  sample_t         s1_x_reg;
  sample_t         s1_hl_reg;
  sample_t         s1_h2l_reg;
  logic            s1_mode_reg;
  logic            s1_valid_reg;
  logic [CH_W-1:0] s1_ch_reg;

  wide_t           x_ext;
  wide_t           hl_ext;
  wide_t           h2l_ext;
  wide_t           y_next;
  wide_t           yout_reg;
  logic            out_valid_reg;
  logic [CH_W-1:0] out_ch_reg;

  assign flush = rst || clr;

  always_comb begin
    lag_next = bus.lag;
    if (bus.lag == '0) begin
      lag_next = LAG_W'(1);
    end else if (int'(bus.lag) > MAX_LAG) begin
      lag_next = LAG_W'(MAX_LAG);
    end
  end

  always_comb begin
    ch_cnt_next = ch_cnt_reg + CH_W'(1);
    if (ch_cnt_reg == CH_W'(NUM_CH - 1)) begin
      ch_cnt_next = '0;
    end
  end

  // One history line per channel; h[k] lives at line_reg[k-1]. The taps are
  // read from pre-shift contents, so back-to-back beats on one channel see
  // the correct x[n-L] without any forwarding.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      sample_t line_reg [HIST_D];
      sample_t tap_l;
      sample_t tap_2l;
      logic    shift_en;

      assign shift_en = bus.in_valid && (ch_cnt_reg == CH_W'(gi));

      always_ff @(posedge clk) begin
        if (flush) begin
          for (int k = 0; k < HIST_D; k++) begin
            line_reg[k] <= '0;
          end
        end else if (shift_en) begin
          line_reg[0] <= bus.Xin;
          for (int k = 1; k < HIST_D; k++) begin
            line_reg[k] <= line_reg[k-1];
          end
        end
      end

      always_comb begin
        tap_l  = '0;
        tap_2l = '0;
        for (int k = 1; k <= MAX_LAG; k++) begin
          if (lag_next == LAG_W'(k)) begin
            tap_l  = line_reg[k-1];
            tap_2l = line_reg[2*k-1];
          end
        end
      end

      assign ch_hl[gi]  = tap_l;
      assign ch_h2l[gi] = tap_2l;
    end
  endgenerate

  always_comb begin
    cur_hl  = '0;
    cur_h2l = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_cnt_reg == CH_W'(c)) begin
        cur_hl  = ch_hl[c];
        cur_h2l = ch_h2l[c];
      end
    end
  end

  // Stage 1: capture the beat with its history taps; clr drops the beat.
  always_ff @(posedge clk) begin
    if (flush) begin
      ch_cnt_reg   <= '0;
      s1_valid_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_hl_reg    <= '0;
      s1_h2l_reg   <= '0;
      s1_mode_reg  <= 1'b0;
      s1_ch_reg    <= '0;
    end else begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        ch_cnt_reg  <= ch_cnt_next;
        s1_x_reg    <= bus.Xin;
        s1_hl_reg   <= cur_hl;
        s1_h2l_reg  <= cur_h2l;
        s1_mode_reg <= bus.mode;
        s1_ch_reg   <= ch_cnt_reg;
      end
    end
  end

  // Two guard bits cover x - 2*h[L] + h[2L] over the full input range.
  always_comb begin
    x_ext   = {{2{s1_x_reg[DATA_W-1]}}, s1_x_reg};
    hl_ext  = {{2{s1_hl_reg[DATA_W-1]}}, s1_hl_reg};
    h2l_ext = {{2{s1_h2l_reg[DATA_W-1]}}, s1_h2l_reg};
    y_next  = x_ext - hl_ext;
    if (s1_mode_reg) begin
      y_next = x_ext - (hl_ext <<< 1) + h2l_ext;
    end
  end

  // Stage 2: result register; Yout/out_ch hold between pulses.
  always_ff @(posedge clk) begin
    if (flush) begin
      out_valid_reg <= 1'b0;
      yout_reg      <= '0;
      out_ch_reg    <= '0;
    end else begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        yout_reg   <= y_next;
        out_ch_reg <= s1_ch_reg;
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.Yout      = yout_reg;
  assign bus.out_ch    = out_ch_reg;
endmodule

// File: tb/tb_sig_diff_mc.sv
// Drives a 1-channel and a 3-channel instance with a shared stream; checks
// table vectors, hand sequences and a random run against a sample-log model.
module tb_sig_diff_mc;
  logic clk;
  logic rst;
  logic clr;
  logic in_valid;
  logic signed [7:0] xin;
  logic [2:0] lag;
  logic mode;

  int checks;
  int errors;

  sig_diff_mc_if #(.DATA_W(8), .NUM_CH(1), .MAX_LAG(4)) bus1 ();
  sig_diff_mc_if #(.DATA_W(8), .NUM_CH(3), .MAX_LAG(4)) bus3 ();

  assign bus1.in_valid = in_valid;
  assign bus1.Xin      = xin;
  assign bus1.lag      = lag;
  assign bus1.mode     = mode;
  assign bus3.in_valid = in_valid;
  assign bus3.Xin      = xin;
  assign bus3.lag      = lag;
  assign bus3.mode     = mode;

  sig_diff_mc #(.DATA_W(8), .NUM_CH(1), .MAX_LAG(4)) dut1 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus1)
  );
  sig_diff_mc #(.DATA_W(8), .NUM_CH(3), .MAX_LAG(4)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each channel keeps a log of every sample since the last
  // rst/clr; results are taken straight from the difference formulas.
  int nch [2] = '{1, 3};
  int samp [2][3][1024];
  int cnt [2][3];
  int chn [2];
  int p_v [2], p_y [2], p_ch [2];
  int e_v [2], e_y [2], e_ch [2];

  function automatic int past(int d, int c, int k);
    int n;
    n = cnt[d][c];
    if (n >= k) return samp[d][c][(n - k) % 1024];
    return 0;
  endfunction

  task automatic model_edge();
    int c, l, x, y;
    for (int d = 0; d < 2; d++) begin
      if (rst || clr) begin
        e_v[d] = 0; e_y[d] = 0; e_ch[d] = 0; p_v[d] = 0; chn[d] = 0;
        for (int k = 0; k < 3; k++) cnt[d][k] = 0;
      end else begin
        e_v[d] = p_v[d];
        if (p_v[d] != 0) begin
          e_y[d] = p_y[d];
          e_ch[d] = p_ch[d];
        end
        p_v[d] = 0;
        if (in_valid) begin
          c = chn[d];
          l = (lag == 0) ? 1 : ((int'(lag) > 4) ? 4 : int'(lag));
          x = int'(xin);
          y = mode ? (x - 2 * past(d, c, l) + past(d, c, 2 * l)) : (x - past(d, c, l));
          p_v[d] = 1; p_y[d] = y; p_ch[d] = c;
          samp[d][c][cnt[d][c] % 1024] = x;
          cnt[d][c]++;
          chn[d] = (c + 1) % nch[d];
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int get_v(int d);
    return (d == 0) ? int'(bus1.out_valid) : int'(bus3.out_valid);
  endfunction
  function automatic int get_y(int d);
    return (d == 0) ? int'(bus1.Yout) : int'(bus3.Yout);
  endfunction
  function automatic int get_ch(int d);
    return (d == 0) ? int'(bus1.out_ch) : int'(bus3.out_ch);
  endfunction

  task automatic cycle(input bit v, input int x, input int l, input bit m, input bit c, input bit r);
    in_valid = v; xin = 8'(x); lag = 3'(l); mode = m; clr = c; rst = r;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d == 0 ? "model_valid_1ch" : "model_valid_3ch", get_v(d), e_v[d]);
      chk(d == 0 ? "model_yout_1ch" : "model_yout_3ch", get_y(d), e_y[d]);
      chk(d == 0 ? "model_outch_1ch" : "model_outch_3ch", get_ch(d), e_ch[d]);
    end
  endtask

  typedef struct {
    int d;
    int x;
    int lag;
    bit mode;
    int exp_y;
    int exp_ch;
  } vec_t;
  vec_t vq[$];

  task automatic add_vec(input int d, input int x, input int l, input bit m, input int ey, input int ec);
    vec_t v;
    v.d = d; v.x = x; v.lag = l; v.mode = m; v.exp_y = ey; v.exp_ch = ec;
    vq.push_back(v);
  endtask

  int tbl_next, tbl_hi, tbl_dut;

  task automatic collect();
    if (get_v(tbl_dut) != 0) begin
      if (tbl_next <= tbl_hi) begin
        $display("vec %0d dut%0d x=%0d yout=%0d exp=%0d ch=%0d", tbl_next, tbl_dut,
                 vq[tbl_next].x, get_y(tbl_dut), vq[tbl_next].exp_y, get_ch(tbl_dut));
        chk("table_yout", get_y(tbl_dut), vq[tbl_next].exp_y);
        chk("table_outch", get_ch(tbl_dut), vq[tbl_next].exp_ch);
      end
      tbl_next++;
    end
  endtask

  task automatic run_group(input int lo, input int hi, input bit gaps);
    tbl_next = lo; tbl_hi = hi; tbl_dut = vq[lo].d;
    cycle(0, 0, 1, 0, 1, 0);
    for (int i = lo; i <= hi; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          cycle(0, 0, 1, 0, 0, 0);
          collect();
        end
      end
      cycle(1, vq[i].x, vq[i].lag, vq[i].mode, 0, 0);
      collect();
    end
    repeat (4) begin
      cycle(0, 0, 1, 0, 0, 0);
      collect();
    end
    chk("table_beat_count", tbl_next, hi + 1);
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    in_valid = 0; xin = 0; lag = 1; mode = 0; clr = 0; rst = 1;

    // Lag-1 first difference, 1 channel (0..3)
    add_vec(0, 5, 1, 0, 5, 0);     add_vec(0, 8, 1, 0, 3, 0);
    add_vec(0, -3, 1, 0, -11, 0);  add_vec(0, 127, 1, 0, 130, 0);
    // Second difference lag 2 (4..9)
    add_vec(0, 1, 2, 1, 1, 0);     add_vec(0, 2, 2, 1, 2, 0);
    add_vec(0, 3, 2, 1, 1, 0);     add_vec(0, 4, 2, 1, 0, 0);
    add_vec(0, 5, 2, 1, 0, 0);     add_vec(0, 6, 2, 1, 0, 0);
    // Extreme second difference (10..14)
    add_vec(0, -128, 2, 1, -128, 0); add_vec(0, 0, 2, 1, 0, 0);
    add_vec(0, 127, 2, 1, 383, 0);   add_vec(0, 0, 2, 1, 0, 0);
    add_vec(0, -128, 2, 1, -510, 0);
    // Interleaved 3 channels (15..20)
    add_vec(1, 10, 1, 0, 10, 0);   add_vec(1, 20, 1, 0, 20, 1);
    add_vec(1, 30, 1, 0, 30, 2);   add_vec(1, 15, 1, 0, 5, 0);
    add_vec(1, 18, 1, 0, -2, 1);   add_vec(1, 40, 1, 0, 10, 2);
    // lag 0 behaves as lag 1 (21..22)
    add_vec(0, 3, 0, 0, 3, 0);     add_vec(0, 10, 0, 0, 7, 0);
    // lag 7 clamps to 4 (23..27)
    add_vec(0, 1, 7, 0, 1, 0);     add_vec(0, 2, 7, 0, 2, 0);
    add_vec(0, 3, 7, 0, 3, 0);     add_vec(0, 4, 7, 0, 4, 0);
    add_vec(0, 9, 7, 0, 8, 0);

    cycle(0, 0, 1, 0, 0, 1);
    cycle(0, 0, 1, 0, 0, 1);
    chk("reset_valid", get_v(0), 0);
    chk("reset_yout", get_y(1), 0);
    chk("reset_outch", get_ch(1), 0);

    run_group(0, 3, 0);
    run_group(4, 9, 0);
    run_group(10, 14, 0);
    run_group(15, 20, 0);
    run_group(21, 22, 0);
    run_group(23, 27, 0);
    run_group(15, 20, 1);
    run_group(15, 20, 1);

    // clr together with a beat while two earlier beats are still unseen
    cycle(0, 0, 1, 0, 1, 0);
    cycle(1, 11, 1, 0, 0, 0);
    cycle(1, 22, 1, 0, 0, 0);
    cycle(1, 33, 1, 0, 0, 0);
    cycle(1, 44, 1, 0, 1, 0);
    chk("clr_kill_a", get_v(1), 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("clr_kill_b", get_v(1), 0);
    cycle(1, -7, 1, 0, 0, 0);
    chk("clr_kill_c", get_v(1), 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("post_clr_valid", get_v(1), 1);
    chk("post_clr_yout", get_y(1), -7);
    chk("post_clr_outch", get_ch(1), 0);

    // Reset pulse inside a continuous stream
    for (int i = 0; i < 12; i++) cycle(1, i * 9 - 50, 2, i % 2, 0, 0);
    cycle(1, 77, 1, 0, 0, 1);
    chk("rst_mid_valid", get_v(0) + get_v(1), 0);
    chk("rst_mid_yout", get_y(0) + get_y(1), 0);
    chk("rst_mid_outch", get_ch(1), 0);
    for (int i = 0; i < 12; i++) cycle(1, 60 - i * 11, 1 + i % 4, i % 3 == 0, 0, 0);

    random_cycles(3000);
    repeat (3) cycle(0, 0, 1, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
